regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two producers: the in-order pipeline writeback stage and the long-latency multdiv unit.
- Holds a multdiv result in a 1-entry buffer until the port is free. Writeback has priority; starvation of the buffered result is bounded by a pipeline-stall request.
- Tracks the one outstanding multdiv destination register, so decode can stall on RAW hazards and a stale result is dropped on WAW.
- Sits between the writeback/multdiv stages and the regfile's ctrl_writeEnable, ctrl_writeReg and data_writeReg inputs.

Parameters:
MAX_WAIT, 4, cycles a buffered multdiv result may wait before pipe_stall asserts (1..7)

Ports:
clock  in  1  system clock, rising edge
ctrl_reset  in  1  asynchronous, active-high reset
wb_valid  in  1  pipeline writeback request this cycle (no backpressure)
wb_reg  in  5  writeback destination register
wb_data  in  32  writeback data
md_issue  in  1  multdiv op issued this cycle
md_issue_reg  in  5  destination of the issued multdiv op
md_valid  in  1  multdiv result valid
md_ready  out  1  arbiter can accept a multdiv result
md_reg  in  5  multdiv result destination
md_data  in  32  multdiv result data
rs_a  in  5  decode source register A
rs_b  in  5  decode source register B
stall_a  out  1  rs_a has a pending multdiv write
stall_b  out  1  rs_b has a pending multdiv write
pipe_stall  out  1  request: pipeline must hold wb_valid low
ctrl_writeEnable  out  1  regfile write enable
ctrl_writeReg  out  5  regfile write address
data_writeReg  out  32  regfile write data

Behaviour:
- Reset (async, ctrl_reset=1):
  - Clears buf_full, pend_valid, pend_squash and wait_cnt.
  - Resulting outputs: md_ready=1, stall_a=stall_b=0, pipe_stall=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0 (when wb_valid=0).
  - Reset mid-operation discards the buffered result and the pending tag.
- Write-port selection (combinational, same cycle):
  - wb_hit = wb_valid && wb_reg!=0.
  - If wb_hit: port drives wb_reg/wb_data with ctrl_writeEnable=1. The buffer is held and wait_cnt increments (saturating at 7).
  - Else if buf_full: buffer drains at the clock edge. Port drives buf_reg/buf_data with ctrl_writeEnable = !pend_squash. Then buf_full<=0, pend_valid<=0, pend_squash<=0, wait_cnt<=0.
  - Else: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - wb_valid with wb_reg==0 never writes and does not block a drain.
- Multdiv accept:
  - md_ready = !buf_full.
  - On md_valid && md_ready, the buffer captures md_reg/md_data and buf_full<=1.
  - Minimum latency: accept at edge N, write at edge N+1.
  - No same-cycle accept-and-drain bypass; a full buffer draining this cycle still shows md_ready=0.
- Pending tracker (single outstanding multdiv op):
  - md_issue with md_issue_reg!=0 and !pend_valid sets pend_valid=1, pend_reg=md_issue_reg, pend_squash=0.
  - md_issue while pend_valid=1 is a protocol violation and is ignored.
  - md_issue to r0 sets nothing.
  - If md_issue and a drain occur in the same cycle, the issue wins: pend_valid stays 1 with the new reg.
- WAW squash:
  - A wb_hit with wb_reg==pend_reg while pend_valid sets pend_squash<=1.
  - The later drain for that entry consumes its slot with ctrl_writeEnable=0, and the stale result is lost.
  - pend_valid stays 1 until the drain.
- RAW stall:
  - stall_a = pend_valid && rs_a==pend_reg && rs_a!=0, and likewise for B.
  - Stall holds through the drain cycle; it clears the cycle after the write edge.
  - No bypass from buffer to decode.
- Starvation:
  - pipe_stall = buf_full && wait_cnt>=MAX_WAIT (registered count, combinational compare).
  - The pipeline must hold wb_valid=0 while pipe_stall=1. If wb_valid is asserted anyway, writeback still wins.

Test Plan:
- Reset with wb_valid=0: md_ready=1, stall_a=0, pipe_stall=0, ctrl_writeEnable=0.
- md_issue r5. Two cycles later md_valid r5=0xDEADBEEF with wb_valid=0. Expect: stall_a=1 while rs_a=5 through the drain cycle; ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF one cycle after accept; stall_a=0 the following cycle.
- Buffer full, wb_valid=1 on r3/r4/r6 for consecutive cycles. Expect: wb writes pass through; pipe_stall=1 after 4 blocked cycles; wb_valid drops; buffer drains next cycle and pipe_stall=0.
- md_issue r7; wb writes r7=0x11; md result r7=0x22 arrives. Expect: drain cycle has ctrl_writeEnable=0, r7 keeps 0x11, pend_valid clears.
- wb_valid=1 with wb_reg=0 while buffer full. Expect: buffer drains that cycle; md_issue to r0 never stalls rs_a=0.
- Assert ctrl_reset while buffer full and pending. Expect: immediate md_ready=1, stall_a=0, no later write of the buffered data.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
//
// Shares the regfile's single write port between the in-order writeback
// stage and the long-latency multdiv unit. Writeback always wins the port;
// a multdiv result waits in a one-entry buffer and drains on the first
// cycle the port is free. The one outstanding multdiv destination is
// tracked so decode can stall on RAW hazards, and a result made stale by a
// younger writeback to the same register (WAW) drains without writing.
// Once a buffered result has waited MAX_WAIT blocked cycles, pipe_stall
// asks the pipeline to hold writeback off so the buffer can drain.
//
// Ports:
//   clock, ctrl_reset                  clock (rising edge), async active-high reset
//   wb_valid, wb_reg, wb_data          writeback request (no backpressure)
//   md_issue, md_issue_reg             multdiv issue and its destination
//   md_valid, md_reg, md_data, md_ready  multdiv result handshake
//   rs_a, rs_b, stall_a, stall_b       decode RAW hazard query
//   pipe_stall                         starvation request to the pipeline
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg  regfile write port
module regfile_write_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_reg,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  input  logic [4:0]  rs_a,
  input  logic [4:0]  rs_b,
  output logic        stall_a,
  output logic        stall_b,
  output logic        pipe_stall,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

  logic              bufFull;
  logic [REG_W-1:0]  bufReg;
  logic [DATA_W-1:0] bufData;
  logic [2:0]        waitCnt;
  logic              pendValid;
  logic              pendSquash;
  logic [REG_W-1:0]  pendReg;

  logic wbHit;
  logic drain;
  logic mdAccept;
  logic issueSet;
  logic wawHit;

  function automatic logic [2:0] satInc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  assign wbHit    = wb_valid && (wb_reg != '0);
  assign drain    = bufFull && !wbHit;
  assign md_ready = !bufFull;
  assign mdAccept = md_valid && !bufFull;
  // A drain frees the tracker in the same cycle, so an issue arriving then
  // is taken rather than treated as a second outstanding op.
  assign issueSet = md_issue && (md_issue_reg != '0) && (!pendValid || drain);
  assign wawHit   = wbHit && pendValid && (wb_reg == pendReg);

  assign stall_a    = pendValid && (rs_a == pendReg) && (rs_a != '0);
  assign stall_b    = pendValid && (rs_b == pendReg) && (rs_b != '0);
  assign pipe_stall = bufFull && (waitCnt >= WAIT_LIMIT);

  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    if (wbHit) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = wb_reg;
      data_writeReg    = wb_data;
    end else if (bufFull) begin
      // A squashed entry still consumes its drain slot, just without writing.
      ctrl_writeEnable = !pendSquash;
      ctrl_writeReg    = bufReg;
      data_writeReg    = bufData;
    end
  end

  // Buffer occupancy and starvation counter
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      bufFull <= 1'b0;
      waitCnt <= '0;
    end else begin
      if (drain) begin
        bufFull <= 1'b0;
      end else if (mdAccept) begin
        bufFull <= 1'b1;
      end
      if (!bufFull || drain) begin
        waitCnt <= '0;
      end else if (wbHit) begin
        waitCnt <= satInc(waitCnt);
      end
    end
  end

  // Buffer payload (no reset needed: only observed while bufFull)
  always_ff @(posedge clock) begin
    if (mdAccept) begin
      bufReg  <= md_reg;
      bufData <= md_data;
    end
  end

  // Pending-destination tracker
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      pendValid  <= 1'b0;
      pendSquash <= 1'b0;
      pendReg    <= '0;
    end else if (issueSet) begin
      pendValid  <= 1'b1;
      pendSquash <= 1'b0;
      pendReg    <= md_issue_reg;
    end else if (drain) begin
      pendValid  <= 1'b0;
      pendSquash <= 1'b0;
    end else if (wawHit) begin
      pendSquash <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Expected regfile writes are
// queued as stimulus is driven and popped whenever the port writes.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        md_issue = 1'b0;
  logic [4:0]  md_issue_reg = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_reg = '0;
  logic [31:0] md_data = '0;
  logic [4:0]  rs_a = '0;
  logic [4:0]  rs_b = '0;
  logic        stall_a;
  logic        stall_b;
  logic        pipe_stall;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t expQ[$];
  int  vectors = 0;
  int  miscompares = 0;

  regfile_write_arbiter #(.MAX_WAIT(4)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .md_issue(md_issue), .md_issue_reg(md_issue_reg),
    .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
    .rs_a(rs_a), .rs_b(rs_b), .stall_a(stall_a), .stall_b(stall_b),
    .pipe_stall(pipe_stall), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic expectWrite(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    expQ.push_back(e);
  endtask

  // Every write seen on the port must match the oldest queued expectation.
  task automatic portMon();
    wr_t e;
    if (ctrl_writeEnable === 1'b1) begin
      vectors++;
      assert (expQ.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_write observed reg=%0d data=%h expected no write",
               ctrl_writeReg, data_writeReg);
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        chk("write_reg", 32'(ctrl_writeReg), 32'(e.r));
        chk("write_data", data_writeReg, e.d);
      end
    end
  endtask

  task automatic sample();
    @(negedge clock);
    portMon();
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 ctrl_reset = 1'b1;
    rs_a = 5'd5;
    rs_b = 5'd5;
    sample();
    chk("rst_md_ready", 32'(md_ready), 1);
    chk("rst_stall_a", 32'(stall_a), 0);
    chk("rst_pipe_stall", 32'(pipe_stall), 0);
    chk("rst_we", 32'(ctrl_writeEnable), 0);
    chk("rst_wreg", 32'(ctrl_writeReg), 0);
    chk("rst_wdata", data_writeReg, 0);
    adv();
    ctrl_reset = 1'b0;

    // Basic multdiv path with RAW stall on r5
    md_issue = 1'b1;
    md_issue_reg = 5'd5;
    sample();
    chk("raw_pre_issue_stall_a", 32'(stall_a), 0);
    adv();
    md_issue = 1'b0;
    sample();
    chk("raw_stall_a", 32'(stall_a), 1);
    chk("raw_stall_b", 32'(stall_b), 1);
    adv();
    md_valid = 1'b1;
    md_reg = 5'd5;
    md_data = 32'hDEADBEEF;
    expectWrite(5'd5, 32'hDEADBEEF);
    sample();
    chk("raw_md_ready_empty", 32'(md_ready), 1);
    chk("raw_no_write_yet", 32'(ctrl_writeEnable), 0);
    adv();
    md_valid = 1'b0;
    sample();
    chk("raw_drain_we", 32'(ctrl_writeEnable), 1);
    chk("raw_stall_through_drain", 32'(stall_a), 1);
    chk("raw_md_ready_full", 32'(md_ready), 0);
    adv();
    sample();
    chk("raw_stall_cleared", 32'(stall_a), 0);
    chk("raw_md_ready_again", 32'(md_ready), 1);

    // Starvation: writeback keeps the port busy while the buffer waits
    adv();
    md_valid = 1'b1;
    md_reg = 5'd9;
    md_data = 32'h0000_0099;
    sample();
    adv();
    md_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1;
      wb_reg = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : (i == 2) ? 5'd6 : 5'd3;
      wb_data = 32'h100 + 32'(i);
      expectWrite(wb_reg, wb_data);
      sample();
      chk("starve_pipe_stall_low", 32'(pipe_stall), 0);
      chk("starve_md_ready", 32'(md_ready), 0);
      adv();
    end
    // Writeback ignoring the stall request still wins the port
    wb_reg = 5'd6;
    wb_data = 32'h666;
    expectWrite(5'd6, 32'h666);
    sample();
    chk("starve_pipe_stall_high", 32'(pipe_stall), 1);
    chk("starve_wb_wins", 32'(ctrl_writeReg), 6);
    adv();
    wb_valid = 1'b0;
    expectWrite(5'd9, 32'h0000_0099);
    sample();
    chk("starve_still_stalled", 32'(pipe_stall), 1);
    chk("starve_drain_reg", 32'(ctrl_writeReg), 9);
    adv();
    sample();
    chk("starve_pipe_stall_clear", 32'(pipe_stall), 0);
    chk("starve_md_ready_clear", 32'(md_ready), 1);

    // WAW squash on r7
    adv();
    md_issue = 1'b1;
    md_issue_reg = 5'd7;
    rs_a = 5'd7;
    rs_b = 5'd0;
    sample();
    adv();
    md_issue = 1'b0;
    wb_valid = 1'b1;
    wb_reg = 5'd7;
    wb_data = 32'h11;
    expectWrite(5'd7, 32'h11);
    sample();
    chk("waw_stall_a", 32'(stall_a), 1);
    adv();
    wb_valid = 1'b0;
    md_valid = 1'b1;
    md_reg = 5'd7;
    md_data = 32'h22;
    sample();
    chk("waw_pending_after_wb", 32'(stall_a), 1);
    adv();
    md_valid = 1'b0;
    sample();
    chk("waw_drain_no_write", 32'(ctrl_writeEnable), 0);
    chk("waw_drain_slot_reg", 32'(ctrl_writeReg), 7);
    chk("waw_stall_in_drain", 32'(stall_a), 1);
    adv();
    sample();
    chk("waw_pend_cleared", 32'(stall_a), 0);
    chk("waw_md_ready", 32'(md_ready), 1);

    // wb to r0 does not block a drain; issue to r0 never stalls
    adv();
    md_valid = 1'b1;
    md_reg = 5'd8;
    md_data = 32'h88;
    expectWrite(5'd8, 32'h88);
    sample();
    adv();
    md_valid = 1'b0;
    wb_valid = 1'b1;
    wb_reg = 5'd0;
    wb_data = 32'hBAD;
    md_issue = 1'b1;
    md_issue_reg = 5'd0;
    rs_a = 5'd0;
    sample();
    chk("r0_drain_we", 32'(ctrl_writeEnable), 1);
    adv();
    wb_valid = 1'b0;
    md_issue = 1'b0;
    sample();
    chk("r0_stall_a", 32'(stall_a), 0);
    chk("r0_md_ready", 32'(md_ready), 1);
    chk("r0_idle_we", 32'(ctrl_writeEnable), 0);

    // Reset mid-operation discards buffered result and pending tag
    adv();
    md_issue = 1'b1;
    md_issue_reg = 5'd10;
    rs_a = 5'd10;
    sample();
    adv();
    md_issue = 1'b0;
    md_valid = 1'b1;
    md_reg = 5'd10;
    md_data = 32'hAA;
    sample();
    adv();
    md_valid = 1'b0;
    chk("mid_full_before_reset", 32'(md_ready), 0);
    chk("mid_stall_before_reset", 32'(stall_a), 1);
    #1 ctrl_reset = 1'b1;
    #1;
    chk("mid_reset_md_ready", 32'(md_ready), 1);
    chk("mid_reset_stall_a", 32'(stall_a), 0);
    chk("mid_reset_we", 32'(ctrl_writeEnable), 0);
    sample();
    adv();
    ctrl_reset = 1'b0;
    sample();
    chk("post_reset_no_write", 32'(ctrl_writeEnable), 0);
    adv();
    sample();
    chk("post_reset_idle_we", 32'(ctrl_writeEnable), 0);

    chk("writes_outstanding", 32'(expQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
